// File: rtl/tmds_decoder_pkg.sv
// tmds_decoder_pkg: control-token constants, FSM encoding and offset wrap helper shared by the TMDS decoder
package tmds_decoder_pkg;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational decode of one aligned 10-bit TMDS symbol into control bits or a data byte
module tmds_symbol_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_ctrl,
  output logic [1:0] c,
  output logic [7:0] d
);
  logic [7:0] t;
  always_comb begin
    is_ctrl = (q == CTRL_00) || (q == CTRL_01) || (q == CTRL_10) || (q == CTRL_11);
    c = (q == CTRL_01) ? 2'b01 : (q == CTRL_10) ? 2'b10 : (q == CTRL_11) ? 2'b11 : 2'b00;
    t = q[9] ? ~q[7:0] : q[7:0];
    d = {t[7:1] ^ t[6:0] ^ {7{~q[8]}}, t[0]};
  end
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS symbol aligner and decoder; define TMDS_DEC_STATS_EN to add slip/lock-loss counters
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int TIMEOUT       = 4096
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic [9:0] raw,
  output logic       locked,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] d,
  output logic [3:0] offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] slip_count,
  output logic [15:0] lock_loss_count
`endif
);
  localparam int RW = $clog2(LOCK_COUNT);
  localparam int SW = $clog2(SEARCH_CYCLES);
  localparam int TW = $clog2(TIMEOUT);
  logic [9:0] cur_q, prev_q, sym;
  logic [19:0] hist;
  logic is_ctrl, slip;
  logic [1:0] sym_c;
  logic [7:0] sym_d;
  state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [SW-1:0] search_q, search_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0] offset_q, offset_d;
  logic de_q, de_d;
  logic [1:0] c_q, c_d;
  logic [7:0] d_q, d_d;
  // prev holds the earlier word, so offset 0 selects a symbol that arrived fully in one word
  assign hist = {cur_q, prev_q};
  assign sym = 10'(hist >> offset_q);
  tmds_symbol_decode u_dec (.q(sym), .is_ctrl(is_ctrl), .c(sym_c), .d(sym_d));
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      cur_q <= '0;
      prev_q <= '0;
      state_q <= HUNT;
      run_q <= '0;
      search_q <= '0;
      to_q <= '0;
      offset_q <= '0;
      de_q <= 1'b0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      cur_q <= raw;
      prev_q <= cur_q;
      state_q <= state_d;
      run_q <= run_d;
      search_q <= search_d;
      to_q <= to_d;
      offset_q <= offset_d;
      de_q <= de_d;
      c_q <= c_d;
      d_q <= d_d;
    end
  end
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    search_d = search_q;
    to_d = to_q;
    slip = 1'b0;
    if (state_q == HUNT) begin
      run_d = is_ctrl ? run_q + 1'b1 : '0;
      search_d = search_q + 1'b1;
      if (is_ctrl && run_q == RW'(LOCK_COUNT - 1)) begin
        state_d = LOCKED;
        run_d = '0;
        search_d = '0;
      end else if (search_q == SW'(SEARCH_CYCLES - 1)) begin
        slip = 1'b1;
        run_d = '0;
        search_d = '0;
      end
    end else begin
      to_d = is_ctrl ? '0 : to_q + 1'b1;
      // a token on the expiry cycle clears to_cnt first, so lock is kept
      if (!is_ctrl && to_q == TW'(TIMEOUT - 1)) begin
        state_d = HUNT;
        slip = 1'b1;
        to_d = '0;
      end
    end
    offset_d = slip ? next_offset(offset_q) : offset_q;
  end
  always_comb begin
    de_d = (state_d == LOCKED) && !is_ctrl;
    c_d = (state_d != LOCKED) ? 2'b00 : is_ctrl ? sym_c : c_q;
    d_d = de_d ? sym_d : 8'h00;
  end
  assign locked = (state_q == LOCKED);
  assign de = de_q;
  assign c = c_q;
  assign d = d_q;
  assign offset = offset_q;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_cnt_q, loss_cnt_q;
  logic loss;
  assign loss = (state_q == LOCKED) && (state_d == HUNT);
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      if (slip && slip_cnt_q != 16'hFFFF) slip_cnt_q <= slip_cnt_q + 1'b1;
      if (loss && loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end
  assign slip_count = slip_cnt_q;
  assign lock_loss_count = loss_cnt_q;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized serial-stream bench with a spec-level reference model and scoreboard
module tb_tmds_decoder;
  localparam int LC = 8;
  localparam int SC = 2048;
  localparam int TO = 4096;
  typedef struct packed {
    logic       lk;
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
    logic [3:0] off;
    logic       sv;
    logic [7:0] src;
  } exp_t;
  logic clk_dot4x = 1'b0;
  logic rst = 1'b1;
  logic [9:0] raw = '0;
  logic locked, de;
  logic [1:0] c;
  logic [7:0] d;
  logic [3:0] offset;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_count, lock_loss_count;
`endif
  tmds_decoder #(.LOCK_COUNT(LC), .SEARCH_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .raw(raw), .locked(locked), .de(de), .c(c), .d(d), .offset(offset)
`ifdef TMDS_DEC_STATS_EN
    , .slip_count(slip_count), .lock_loss_count(lock_loss_count)
`endif
  );
  always #5 clk_dot4x = ~clk_dot4x;
  exp_t sbq[$];
  exp_t me;
  bit sbits[$];
  int total = 0, bad = 0;
  logic [9:0] toks[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  int enc_cnt = 0;
  logic [9:0] w_cur = '0, w_prev = '0;
  int t_cur = -1, t_prev = -1;
  bit m_lk = 0;
  int m_run = 0, m_srch = 0, m_to = 0, m_off = 0, skew = 0;
  logic [1:0] m_c = '0;

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // DVI transmit encoder with running disparity, used as the stimulus source
  function automatic logic [9:0] enc(input logic [7:0] b);
    logic [8:0] qm;
    logic [9:0] o;
    int n1, n0;
    n1 = ones8(b);
    qm[0] = b[0];
    if (n1 > 4 || (n1 == 4 && !b[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
      qm[8] = 1'b1;
    end
    n1 = ones8(qm[7:0]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? n1 - n0 : n0 - n1;
    end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -(qm[8] ? 0 : 2) + n1 - n0;
    end
    return o;
  endfunction

  function automatic logic [9:0] tok(input int i);
    enc_cnt = 0;
    return toks[i];
  endfunction

  task automatic model_step(output exp_t e);
    logic [19:0] h;
    logic [9:0] s;
    logic [7:0] tt, dd;
    bit tk;
    int tc;
    h = {w_cur, w_prev} >> m_off;
    s = h[9:0];
    tk = 0;
    tc = 0;
    for (int i = 0; i < 4; i++) if (s == toks[i]) begin tk = 1; tc = i; end
    if (!m_lk) begin
      m_run = tk ? m_run + 1 : 0;
      if (m_run == LC) begin m_lk = 1; m_run = 0; m_srch = 0; m_to = 0; end
      else if (m_srch == SC - 1) begin m_off = (m_off + 1) % 10; m_run = 0; m_srch = 0; end
      else m_srch++;
    end else if (tk) m_to = 0;
    else if (m_to == TO - 1) begin m_lk = 0; m_off = (m_off + 1) % 10; m_to = 0; m_run = 0; m_srch = 0; end
    else m_to++;
    tt = s[9] ? ~s[7:0] : s[7:0];
    dd[0] = tt[0];
    for (int i = 1; i < 8; i++) dd[i] = s[8] ? tt[i] ^ tt[i-1] : ~(tt[i] ^ tt[i-1]);
    if (!m_lk) m_c = 2'b00;
    else if (tk) m_c = 2'(tc);
    e.lk = m_lk;
    e.de = m_lk && !tk;
    e.c = m_c;
    e.d = (m_lk && !tk) ? dd : 8'h00;
    e.off = 4'(m_off);
    e.sv = m_lk && !tk && t_prev >= 0 && m_off == skew;
    e.src = 8'(t_prev);
  endtask

  task automatic send(input logic [9:0] sym, input int tag);
    exp_t e;
    logic [9:0] r;
    @(negedge clk_dot4x);
    model_step(e);
    sbq.push_back(e);
    for (int i = 0; i < 10; i++) sbits.push_back(sym[i]);
    for (int i = 0; i < 10; i++) r[i] = sbits.pop_front();
    w_prev = w_cur;
    w_cur = r;
    t_prev = t_cur;
    t_cur = tag;
    raw = r;
    rst = 1'b0;
    @(posedge clk_dot4x);
  endtask

  task automatic send_data(input logic [7:0] b);
    send(enc(b), int'(b));
  endtask

  task automatic do_reset(input int sk);
    @(negedge clk_dot4x);
    sbq.push_back('0);
    m_lk = 0; m_run = 0; m_srch = 0; m_to = 0; m_off = 0; m_c = '0;
    w_cur = '0; w_prev = '0; t_cur = -1; t_prev = -1; enc_cnt = 0;
    sbits.delete();
    skew = sk;
    for (int i = 0; i < sk; i++) sbits.push_back(bit'($urandom_range(1)));
    rst = 1'b1;
    raw = 10'($urandom);
    @(posedge clk_dot4x);
  endtask

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, x);
    end
  endtask

  always @(posedge clk_dot4x) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("scoreboard{lk,de,c,d,off}", {locked, de, c, d, offset}, {me.lk, me.de, me.c, me.d, me.off});
      if (me.sv) chk("loopback{de,d}", {7'd0, de, d}, {7'd0, 1'b1, me.src});
    end
  end

  initial begin
    do_reset(0);
    do_reset(0);
    for (int i = 0; i < 20; i++) send(tok(0), -1);
    #2;
    chk("aligned_lock", {14'd0, locked, de}, 16'h0002);
    chk("aligned_off_c", {10'd0, c, offset}, 16'h0000);
    send_data(8'hA5);
    send_data(8'(($urandom)));
    send_data(8'(($urandom)));
    #2;
    chk("a5_decode", {7'd0, de, d}, 16'h01A5);
    for (int i = 0; i < 256; i++) begin
      if (i % 16 == 0) send(tok($urandom_range(3)), -1);
      send_data(8'(i));
    end
    send(tok(0), -1);
    for (int i = 0; i < TO - 1; i++) send_data(8'($urandom));
    send(tok(2), -1);
    send(tok(0), -1);
    send(tok(0), -1);
    #2;
    chk("token_wins_expiry", {15'd0, locked}, 16'h0001);
    for (int i = 0; i < TO; i++) send_data(8'($urandom));
    send(tok(0), -1);
    send(tok(0), -1);
    #2;
    chk("timeout_unlock", {11'd0, locked, offset}, 16'h0001);
    for (int i = 0; i < 9 * SC + 20; i++) send(tok(0), -1);
    #2;
    chk("wrap_relock", {11'd0, locked, offset}, 16'h0010);
`ifdef TMDS_DEC_STATS_EN
    chk("stats_slips", slip_count, 16'd10);
    chk("stats_losses", lock_loss_count, 16'd1);
`endif
    do_reset(3);
    #2;
    chk("reset_midlock", {locked, de, c, d, offset}, 16'h0000);
`ifdef TMDS_DEC_STATS_EN
    chk("stats_reset", {slip_count[7:0], lock_loss_count[7:0]}, 16'h0000);
`endif
    for (int i = 0; i < 3 * SC + 20; i++) send(tok(0), -1);
    #2;
    chk("skew3_lock", {11'd0, locked, offset}, 16'h0013);
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) send(tok($urandom_range(3)), -1);
      else send_data(8'($urandom));
    end
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
